// File: rtl/clock_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | clock_pkg : shared state codes, BCD limits and digit type for the clock  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package clock_pkg;

    typedef logic [3:0] bcd_t;
    typedef logic [1:0] mode_t;

    localparam mode_t ST_RUN        = 2'd0;
    localparam mode_t ST_SET_HOUR   = 2'd1;
    localparam mode_t ST_SET_MINUTE = 2'd2;

    localparam bcd_t HOUR_MAX_T      = 4'd2;
    localparam bcd_t HOUR_MAX_U_AT_2 = 4'd3;
    localparam bcd_t MIN_MAX_T       = 4'd5;
    localparam bcd_t DIGIT_MAX       = 4'd9;

endpackage
`default_nettype wire

// File: rtl/button_debouncer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | button_debouncer : 2-flop synchroniser, stability filter, rise pulse     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module button_debouncer #(
    parameter int unsigned DB_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_btn,
    output logic o_level,
    output logic o_press
);

    localparam int unsigned c_cnt_w = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DB_CYCLES - 1);

    logic               r_sync1;
    logic               r_sync2;
    logic               r_level;
    logic               r_level_d;
    logic [c_cnt_w-1:0] r_cnt;

    // Level flips only after DB_CYCLES consecutive samples disagreeing with it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1   <= 1'b0;
            r_sync2   <= 1'b0;
            r_level   <= 1'b0;
            r_level_d <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_sync1   <= i_btn;
            r_sync2   <= r_sync1;
            r_level_d <= r_level;
            if (r_sync2 == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == c_cnt_last) begin
                r_level <= r_sync2;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_level = r_level;
    assign o_press = r_level & ~r_level_d;

endmodule
`default_nettype wire

// File: rtl/clock_set_controller.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | clock_set_controller : button-driven HH:MM edit FSM with counter load    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module clock_set_controller
    import clock_pkg::*;
#(
    parameter int unsigned DB_CYCLES  = 1_000_000,
    parameter int unsigned RPT_DELAY  = 25_000_000,
    parameter int unsigned RPT_PERIOD = 5_000_000,
    parameter int unsigned BLINK_HALF = 12_500_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic [3:0] cur_hh_t,
    input  logic [3:0] cur_hh_u,
    input  logic [3:0] cur_mm_t,
    input  logic [3:0] cur_mm_u,
    output logic [3:0] set_hh_t,
    output logic [3:0] set_hh_u,
    output logic [3:0] set_mm_t,
    output logic [3:0] set_mm_u,
    output logic       load,
    output logic       run_en,
    output logic       blank_hh,
    output logic       blank_mm,
    output logic [1:0] mode_st
);

    localparam int unsigned c_rpt_w = $clog2(RPT_DELAY + 1);
    localparam logic [c_rpt_w-1:0] c_rpt_fire   = c_rpt_w'(RPT_DELAY);
    localparam logic [c_rpt_w-1:0] c_rpt_reload = c_rpt_w'(RPT_DELAY - RPT_PERIOD + 1);
    localparam int unsigned c_blk_w = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam logic [c_blk_w-1:0] c_blk_last = c_blk_w'(BLINK_HALF - 1);

    logic               w_mode_press;
    logic               w_inc_press;
    logic               w_inc_level;
    logic               w_in_set;
    logic               w_rpt_fire;
    logic               w_inc;
    logic               w_cur_valid;
    bcd_t               w_hh_t_nx, w_hh_u_nx, w_mm_t_nx, w_mm_u_nx;

    mode_t              r_state;
    bcd_t               r_hh_t, r_hh_u, r_mm_t, r_mm_u;
    logic               r_load;
    logic               r_run_en;
    logic               r_blink_on;
    logic [c_blk_w-1:0] r_blink_cnt;
    logic [c_rpt_w-1:0] r_rpt_cnt;
    logic               r_rpt_block;

    button_debouncer #(.DB_CYCLES(DB_CYCLES)) u_db_mode (
        .clk     (clk),
        .rst     (rst),
        .i_btn   (btn_mode),
        .o_level (),
        .o_press (w_mode_press)
    );

    button_debouncer #(.DB_CYCLES(DB_CYCLES)) u_db_inc (
        .clk     (clk),
        .rst     (rst),
        .i_btn   (btn_inc),
        .o_level (w_inc_level),
        .o_press (w_inc_press)
    );

    assign w_in_set   = (r_state != ST_RUN);
    assign w_rpt_fire = w_in_set & w_inc_level & ~r_rpt_block & (r_rpt_cnt == c_rpt_fire);
    // MODE has priority: an INC event in the same cycle is dropped.
    assign w_inc      = w_in_set & ~w_mode_press & (w_inc_press | w_rpt_fire);

    assign w_cur_valid = (cur_hh_t <= DIGIT_MAX) && (cur_hh_u <= DIGIT_MAX) &&
                         (cur_mm_t <= MIN_MAX_T) && (cur_mm_u <= DIGIT_MAX) &&
                         ((cur_hh_t < HOUR_MAX_T) ||
                          ((cur_hh_t == HOUR_MAX_T) && (cur_hh_u <= HOUR_MAX_U_AT_2)));

    always_comb begin
        w_hh_t_nx = r_hh_t;
        w_hh_u_nx = r_hh_u + 4'd1;
        if ((r_hh_t == HOUR_MAX_T) && (r_hh_u == HOUR_MAX_U_AT_2)) begin
            w_hh_t_nx = '0;
            w_hh_u_nx = '0;
        end else if (r_hh_u == DIGIT_MAX) begin
            w_hh_t_nx = r_hh_t + 4'd1;
            w_hh_u_nx = '0;
        end
        w_mm_t_nx = r_mm_t;
        w_mm_u_nx = r_mm_u + 4'd1;
        if (r_mm_u == DIGIT_MAX) begin
            w_mm_u_nx = '0;
            w_mm_t_nx = (r_mm_t == MIN_MAX_T) ? 4'd0 : r_mm_t + 4'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_RUN;
            r_hh_t   <= '0;
            r_hh_u   <= '0;
            r_mm_t   <= '0;
            r_mm_u   <= '0;
            r_load   <= 1'b0;
            r_run_en <= 1'b1;
        end else begin
            r_load <= 1'b0;
            if (w_mode_press) begin
                case (r_state)
                    ST_RUN: begin
                        r_state  <= ST_SET_HOUR;
                        r_run_en <= 1'b0;
                        if (w_cur_valid) begin
                            r_hh_t <= cur_hh_t;
                            r_hh_u <= cur_hh_u;
                            r_mm_t <= cur_mm_t;
                            r_mm_u <= cur_mm_u;
                        end else begin
                            r_hh_t <= '0;
                            r_hh_u <= '0;
                            r_mm_t <= '0;
                            r_mm_u <= '0;
                        end
                    end
                    ST_SET_HOUR: begin
                        r_state <= ST_SET_MINUTE;
                    end
                    ST_SET_MINUTE: begin
                        r_state  <= ST_RUN;
                        r_load   <= 1'b1;
                        r_run_en <= 1'b1;
                    end
                    default: begin
                        r_state  <= ST_RUN;
                        r_run_en <= 1'b1;
                    end
                endcase
            end else if (w_inc) begin
                if (r_state == ST_SET_HOUR) begin
                    r_hh_t <= w_hh_t_nx;
                    r_hh_u <= w_hh_u_nx;
                end else begin
                    r_mm_t <= w_mm_t_nx;
                    r_mm_u <= w_mm_u_nx;
                end
            end
        end
    end

    // An INC still held across a MODE change stays blocked until released.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rpt_cnt   <= '0;
            r_rpt_block <= 1'b0;
        end else begin
            r_rpt_block <= w_mode_press ? w_inc_level : (r_rpt_block & w_inc_level);
            if (w_mode_press || !w_in_set || !w_inc_level || r_rpt_block) begin
                r_rpt_cnt <= '0;
            end else if (w_rpt_fire) begin
                r_rpt_cnt <= c_rpt_reload;
            end else begin
                r_rpt_cnt <= r_rpt_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_blink_on  <= 1'b0;
            r_blink_cnt <= '0;
        end else if (w_mode_press || w_inc) begin
            r_blink_on  <= 1'b1;
            r_blink_cnt <= '0;
        end else if (r_blink_cnt == c_blk_last) begin
            r_blink_on  <= ~r_blink_on;
            r_blink_cnt <= '0;
        end else begin
            r_blink_cnt <= r_blink_cnt + 1'b1;
        end
    end

    assign set_hh_t = r_hh_t;
    assign set_hh_u = r_hh_u;
    assign set_mm_t = r_mm_t;
    assign set_mm_u = r_mm_u;
    assign load     = r_load;
    assign run_en   = r_run_en;
    assign mode_st  = r_state;
    assign blank_hh = (r_state == ST_SET_HOUR)   & ~r_blink_on;
    assign blank_mm = (r_state == ST_SET_MINUTE) & ~r_blink_on;

endmodule
`default_nettype wire

// File: doc/clock_set_controller.md
Name: clock_set_controller

Overview:
Upstream control stage for the digital clock's BCD time counters. Debounces two raw push-buttons (MODE, INC) and runs a RUN / SET_HOUR / SET_MINUTE state machine. Edits a shadow copy of HH:MM with wrap-around and auto-repeat, then emits a one-cycle parallel-load strobe to the counters. Drives the counter run-enable and per-field blank requests so the display can blink the field being edited.

Parameters:
DB_CYCLES, 1_000_000, cycles a raw button must be stable before its debounced level changes (20 ms at 50 MHz)
RPT_DELAY, 25_000_000, cycles INC must be held before auto-repeat starts (500 ms)
RPT_PERIOD, 5_000_000, cycles between auto-repeat increments (100 ms)
BLINK_HALF, 12_500_000, half-period of the edit-field blink in cycles (2 Hz)

Ports:
clk  in  1  system clock, 50 MHz
rst  in  1  reset, asynchronous, active-high
btn_mode  in  1  raw MODE button, active-high, asynchronous to clk
btn_inc  in  1  raw INC button, active-high, asynchronous to clk
cur_hh_t  in  4  current hour tens (BCD) from counters
cur_hh_u  in  4  current hour units (BCD)
cur_mm_t  in  4  current minute tens (BCD)
cur_mm_u  in  4  current minute units (BCD)
set_hh_t  out  4  edited hour tens
set_hh_u  out  4  edited hour units
set_mm_t  out  4  edited minute tens
set_mm_u  out  4  edited minute units
load  out  1  one-cycle strobe: counters load set_* and clear seconds to 00
run_en  out  1  1 = counters advance; 0 = counters hold
blank_hh  out  1  hour digits must be blanked this cycle
blank_mm  out  1  minute digits must be blanked this cycle
mode_st  out  2  state code: 0 RUN, 1 SET_HOUR, 2 SET_MINUTE

Behaviour:
- Reset values: set_* = 0, load = 0, run_en = 1, blank_* = 0, mode_st = RUN. Debouncer levels = 0. Repeat and blink counters = 0.
- Debounce, per button: 2-flop synchroniser. The debounced level follows the synchronised input only after DB_CYCLES consecutive equal samples. Any mismatch restarts the count.
- press = one-cycle pulse on each rising edge of the debounced level. Release produces no pulse.
- Latency: the press pulse occurs 2 + DB_CYCLES cycles after a clean raw edge. The state change or field update registers on the cycle after the pulse.
- RUN, mode press:
  - Go to SET_HOUR; run_en drops to 0 in the same registered cycle.
  - Capture cur_* into the shadow registers.
  - If the captured hour is > 23, or any captured digit is > 9, or minute tens is > 5, capture 00:00 instead.
- SET_HOUR, mode press: go to SET_MINUTE.
- SET_MINUTE, mode press: go to RUN. load = 1 and run_en = 1 in that same cycle; load deasserts on the next cycle.
- INC press in SET_HOUR: hour += 1 in BCD, 09->10, 19->20, 23->00.
- INC press in SET_MINUTE: minute += 1 in BCD, 09->10, 59->00. Tens and units always update together as one value.
- INC in RUN: ignored.
- Auto-repeat:
  - While debounced INC is held in a SET state, one extra increment fires after RUN_DELAY... specifically after RPT_DELAY cycles held, then one every RPT_PERIOD cycles.
  - Repeat counter clears on release and on any state change.
- Simultaneous MODE and INC press pulses in the same cycle: MODE wins, INC is discarded. INC being held (auto-repeat) across a MODE change does not increment the new field until INC is released and pressed again.
- Blink:
  - blink_on toggles every BLINK_HALF cycles.
  - Forced to 1 and its counter cleared on entry to a SET state and on every increment, so the value is visible after each edit.
  - blank_hh = (SET_HOUR & ~blink_on); blank_mm = (SET_MINUTE & ~blink_on).
  - Both are 0 in RUN.
- set_* hold their value at all times; they are only meaningful at load.
- Reset mid-edit: return to RUN immediately, no load, shadow registers cleared.
- load is never asserted outside the SET_MINUTE->RUN transition.

Decomposition:
- Shared package clock_pkg:
  - mode-state encoding (RUN, SET_HOUR, SET_MINUTE)
  - BCD limit constants: HOUR_MAX_T=2, HOUR_MAX_U_AT_2=3, MIN_MAX_T=5, DIGIT_MAX=9
  - 4-bit BCD digit typedef
- One sub-module: button_debouncer (synchroniser, stability counter, level out, rise-pulse out), instantiated twice.
- BCD increment logic stays inline.

Test Plan:
Bench parameters: DB_CYCLES=4, RPT_DELAY=20, RPT_PERIOD=5, BLINK_HALF=8.
1. Glitches: 3-cycle btn_mode glitches repeated -> no press, mode_st stays 0, run_en=1. Clean hold of 10 cycles -> mode_st=1 exactly 7 cycles after the raw edge.
2. cur=23:59, MODE, INC x1 -> set=00:59. MODE, INC x1 -> set=00:00. MODE -> load high for exactly 1 cycle, set=00:00, run_en=1.
3. Entering from cur=09:09: hour INC -> 10. Minute INC steps from 09 -> 10 and from 59 -> 00.
4. Hold INC 40 debounced cycles in SET_MINUTE from 00 -> minute=05 (1 press + repeats at 20, 25, 30, 35).
5. MODE and INC pulse in the same cycle in SET_HOUR -> mode_st=2, hour unchanged. cur=2,7:6,A on entry -> shadow 00:00.
6. Assert rst while in SET_MINUTE -> mode_st=0, run_en=1, set_*=0, no load pulse; blank_hh toggles with period 16 in SET_HOUR only.
